// File: rtl/port_uart_tx.sv
// 8N1 UART transmitter with a one-entry pending buffer and a sticky overrun flag.
// Control and status are laid out for byte-wide computer output/input ports.
module port_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       clr_overrun,
    output logic       tx_serial,
    output logic       tx_busy,
    output logic       tx_done,
    output logic [7:0] tx_status
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    state_e      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  pend_q, pend_d;
    logic        pend_valid_q, pend_valid_d;
    logic        overrun_q, overrun_d;
    logic        start_q, start_d;
    logic        serial_q, serial_d;
    logic        done_q, done_d;

    logic start_edge;
    logic bit_end;
    logic handoff;
    logic overrun_set;

    assign start_edge = tx_start && !start_q;
    assign bit_end    = (baud_q == BAUD_LAST);
    assign handoff    = (state_q == STOP) && bit_end;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            baud_q       <= '0;
            bit_idx_q    <= '0;
            shreg_q      <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            start_q      <= 1'b1;  // a start held high through reset must not fire
            serial_q     <= 1'b1;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            bit_idx_q    <= bit_idx_d;
            shreg_q      <= shreg_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            overrun_q    <= overrun_d;
            start_q      <= start_d;
            serial_q     <= serial_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        baud_d       = baud_q;
        bit_idx_d    = bit_idx_q;
        shreg_d      = shreg_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        serial_d     = serial_q;
        done_d       = 1'b0;
        start_d      = tx_start;
        overrun_set  = 1'b0;

        // Requests arriving mid-frame queue up; the frame-end cycle is handled below.
        if (state_q != IDLE && start_edge && !handoff) begin
            if (!pend_valid_q) begin
                pend_d       = tx_data;
                pend_valid_d = 1'b1;
            end else begin
                overrun_set = 1'b1;
            end
        end

        if (state_q != IDLE) begin
            baud_d = bit_end ? 16'd0 : baud_q + 16'd1;
        end

        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (start_edge) begin
                    state_d  = START;
                    shreg_d  = tx_data;
                    serial_d = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                    serial_d  = shreg_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d  = STOP;
                        serial_d = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shreg_d   = shreg_q >> 1;
                        serial_d  = shreg_q[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    done_d = 1'b1;
                    if (pend_valid_q) begin
                        state_d      = START;
                        shreg_d      = pend_q;
                        serial_d     = 1'b0;
                        pend_valid_d = start_edge;
                        if (start_edge) begin
                            pend_d = tx_data;
                        end
                    end else if (start_edge) begin
                        state_d  = START;
                        shreg_d  = tx_data;
                        serial_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A new overrun in the same cycle as a clear request keeps the flag set.
    assign overrun_d = overrun_set || (overrun_q && !clr_overrun);

    assign tx_serial = serial_q;
    assign tx_busy   = (state_q != IDLE);
    assign tx_done   = done_q;
    assign tx_status = {5'b0, overrun_q, pend_valid_q, tx_busy};

endmodule

// File: tb/tb_port_uart_tx.sv
// Bench for port_uart_tx: frame-pattern table, directed corner sequences and a
// randomized run, all checked against a frame-timeline reference model.
module tb_port_uart_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       clr_overrun = 1'b0;
    logic       tx_serial, tx_busy, tx_done;
    logic [7:0] tx_status;

    int n_tests = 0;
    int n_fail  = 0;

    port_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .reset       (rst_n),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .clr_overrun (clr_overrun),
        .tx_serial   (tx_serial),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_status   (tx_status)
    );

    always #5 clk = ~clk;

    // Reference model: a frame is a 10*CPB-cycle window starting at the clock
    // edge that launched it; everything else is derived from that timeline.
    int         t = 0;
    int         cur_s = -1;
    logic [7:0] cur_byte = 8'h00;
    logic       pend_v = 1'b0;
    logic [7:0] pend_b = 8'h00;
    logic       ov = 1'b0;
    logic       prev_start = 1'b1;
    logic       e_serial = 1'b1, e_busy = 1'b0, e_done = 1'b0;
    logic [7:0] e_status = 8'h00;

    function automatic void model_outputs();
        int b;
        if (cur_s < 0) begin
            e_serial = 1'b1;
        end else begin
            b = (t - cur_s) / CPB;
            if (b == 0)      e_serial = 1'b0;
            else if (b == 9) e_serial = 1'b1;
            else             e_serial = cur_byte[b-1];
        end
        e_busy   = (cur_s >= 0);
        e_status = {5'b0, ov, pend_v, e_busy};
    endfunction

    function automatic void model_reset();
        cur_s = -1; pend_v = 1'b0; ov = 1'b0; prev_start = 1'b1; e_done = 1'b0;
        model_outputs();
    endfunction

    function automatic void model_step();
        logic edge_seen, ending, set_ov;
        t = t + 1;
        if (!rst_n) begin
            model_reset();
            return;
        end
        edge_seen  = tx_start && !prev_start;
        prev_start = tx_start;
        set_ov     = 1'b0;
        ending     = (cur_s >= 0) && (t == cur_s + FRAME);
        e_done     = ending;
        if (ending) begin
            if (pend_v) begin
                cur_s = t; cur_byte = pend_b; pend_v = edge_seen;
                if (edge_seen) pend_b = tx_data;
            end else if (edge_seen) begin
                cur_s = t; cur_byte = tx_data;
            end else begin
                cur_s = -1;
            end
        end else if (cur_s >= 0) begin
            if (edge_seen) begin
                if (!pend_v) begin pend_v = 1'b1; pend_b = tx_data; end
                else set_ov = 1'b1;
            end
        end else if (edge_seen) begin
            cur_s = t; cur_byte = tx_data;
        end
        ov = set_ov || (ov && !clr_overrun);
        model_outputs();
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0d)", name, act, exp, t);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("model", {21'b0, tx_serial, tx_busy, tx_done, tx_status},
                       {21'b0, e_serial, e_busy, e_done, e_status});
    endtask

    // Drive a 0->1 on tx_start with the given byte; the edge lands on this tick.
    task automatic send(input logic [7:0] d);
        tx_data = d; tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] bits;      // serial order, bit 0 first on the line
        int         done_at;   // cycles from first start-bit sample to tx_done
    } vec_t;

    vec_t vecs[6];
    logic ser_s[64];
    int   done_cnt, busy_cnt, done_idx;

    initial begin
        vecs[0] = '{8'hA5, 10'b1101001010, 40};
        vecs[1] = '{8'h00, 10'b1000000000, 40};
        vecs[2] = '{8'hFF, 10'b1111111110, 40};
        vecs[3] = '{8'h01, 10'b1000000010, 40};
        vecs[4] = '{8'h80, 10'b1100000000, 40};
        vecs[5] = '{8'h3C, 10'b1001111000, 40};

        // Reset state
        model_reset();
        for (int i = 0; i < 3; i++) tick();
        check("rst_serial", {31'b0, tx_serial}, 32'd1);
        check("rst_status", {24'b0, tx_status}, 32'h00);
        check("rst_done",   {31'b0, tx_done},   32'd0);
        rst_n = 1'b1;
        tick();

        // Frame pattern table
        foreach (vecs[k]) begin
            tick();
            send(vecs[k].data);
            ser_s[0] = tx_serial;
            done_idx = -1;
            if (tx_done) done_idx = 0;
            for (int i = 1; i < 60; i++) begin
                tick();
                ser_s[i] = tx_serial;
                if (tx_done && done_idx < 0) done_idx = i;
            end
            for (int b = 0; b < 10; b++)
                check($sformatf("vec%0d_bit%0d", k, b), {31'b0, ser_s[b*CPB + CPB/2]},
                      {31'b0, vecs[k].bits[b]});
            check($sformatf("vec%0d_done_at", k), done_idx, vecs[k].done_at);
            check($sformatf("vec%0d_idle_busy", k), {31'b0, tx_busy}, 32'd0);
        end

        // Back-to-back: 01 then FF pulsed during a data bit
        tick();
        send(8'h01);
        done_cnt = 0;
        for (int i = 1; i < 100; i++) begin
            if (i == 13) begin tx_data = 8'hFF; tx_start = 1'b1; end
            else tx_start = 1'b0;
            tick();
            if (tx_done) done_cnt++;
            if (i == 13) check("b2b_status", {24'b0, tx_status}, 32'h03);
            if (i == 40) check("b2b_handoff_serial", {31'b0, tx_serial}, 32'd0);
        end
        check("b2b_done_count", done_cnt, 2);

        // Overrun: third request within one frame is dropped
        tick();
        send(8'h11);
        done_cnt = 0;
        for (int i = 1; i < 100; i++) begin
            tx_start = (i == 5) || (i == 10);
            tx_data  = (i == 5) ? 8'h22 : 8'h33;
            tick();
            if (tx_done) done_cnt++;
            if (i == 10) check("ovr_flag_set", {31'b0, tx_status[2]}, 32'd1);
        end
        tx_start = 1'b0;
        check("ovr_done_count", done_cnt, 2);
        clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
        check("ovr_cleared", {31'b0, tx_status[2]}, 32'd0);

        // Set wins over simultaneous clear
        send(8'h44);
        for (int i = 1; i < 100; i++) begin
            tx_start    = (i == 5) || (i == 10);
            tx_data     = (i == 5) ? 8'h55 : 8'h66;
            clr_overrun = (i == 10);
            tick();
            if (i == 10) check("setclr_overrun", {31'b0, tx_status[2]}, 32'd1);
        end
        tx_start = 1'b0; clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;

        // Request exactly on the frame-end cycle with an empty slot
        send(8'h5A);
        for (int i = 1; i < 40; i++) tick();
        send(8'hC3);
        check("end_edge_done",   {31'b0, tx_done},   32'd1);
        check("end_edge_status", {24'b0, tx_status}, 32'h01);
        check("end_edge_serial", {31'b0, tx_serial}, 32'd0);
        for (int i = 0; i < 45; i++) tick();

        // Request on the hand-off cycle refills the freed slot, no overrun
        send(8'h12);
        for (int i = 1; i < 40; i++) begin
            tx_start = (i == 5); tx_data = 8'h34;
            tick();
        end
        send(8'h56);
        check("handoff_edge_status", {24'b0, tx_status}, 32'h03);
        for (int i = 0; i < 90; i++) tick();

        // Reset mid-frame with a pending byte
        send(8'hAA);
        for (int i = 1; i <= 21; i++) begin
            tx_start = (i == 5); tx_data = 8'hBB;
            tick();
        end
        tx_start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst_serial", {31'b0, tx_serial}, 32'd1);
        check("midrst_status", {24'b0, tx_status}, 32'h00);
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b1;
        done_cnt = 0; busy_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (tx_done) done_cnt++;
            if (tx_busy) busy_cnt++;
        end
        check("midrst_no_done", done_cnt, 0);
        check("midrst_no_frame", busy_cnt, 0);

        // tx_start held high across reset release
        tx_start = 1'b1;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (tx_busy) busy_cnt++;
        end
        check("held_no_frame", busy_cnt, 0);
        tx_start = 1'b0; tick();
        send(8'h96);
        done_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (tx_done) done_cnt++;
        end
        check("held_one_frame", done_cnt, 1);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) tx_start = ~tx_start;
            tx_data     = 8'($urandom);
            clr_overrun = ($urandom_range(0, 40) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/port_uart_tx.md
PORT_UART_TX -- requirements
Module: port_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, SHALL set the clock cycles per serial bit; legal range 2..65535.
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 reset  input  1  SHALL be the asynchronous, active-low reset (0 = reset asserted).
REQ-004 tx_data  input  8  SHALL be the byte to send, driven from a computer output port.
REQ-005 tx_start  input  1  SHALL be the send request; a 0->1 transition requests one frame (driven from a computer output port bit).
REQ-006 clr_overrun  input  1  SHALL be a level; while 1, it clears the sticky overrun flag.
REQ-007 tx_serial  output  1  SHALL be the serial line, idle high.
REQ-008 tx_busy  output  1  SHALL be 1 whenever the state is not IDLE.
REQ-009 tx_done  output  1  SHALL pulse high for exactly one cycle per completed frame.
REQ-010 tx_status  output  8  SHALL equal {5'b0, overrun, pend_valid, tx_busy}, for wiring to a computer input port.

Function
REQ-011 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1); each bit held for exactly CLKS_PER_BIT cycles; frame length 10*CLKS_PER_BIT cycles.
REQ-012 Start detection SHALL use a registered copy start_q of tx_start.
- Edge when tx_start=1 and start_q=0 at a rising clk edge.
- tx_data captured at that same edge.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP.
- IDLE->START on edge.
- START->DATA after CLKS_PER_BIT cycles.
- DATA->STOP after 8 bits (3-bit index 0..7).
- STOP->IDLE or STOP->START (REQ-016) after CLKS_PER_BIT cycles.
REQ-014 Latency: with an edge sampled at edge N in IDLE, tx_serial SHALL be 0 from cycle N+1, and tx_busy SHALL be 1 from cycle N+1.
REQ-015 tx_done SHALL be 1 in the cycle immediately following the last stop-bit cycle, coincident with the state leaving STOP.
REQ-016 Pending buffer: one 8-bit entry plus pend_valid.
- Edge while busy and pend_valid=0: capture tx_data, set pend_valid.
- At end of STOP with pend_valid=1: go directly to START with the pending byte and clear pend_valid.
- No idle gap between frames; tx_done still pulses.
REQ-017 Overrun: an edge while busy and pend_valid=1 SHALL drop the byte, leave the pending byte unchanged, and set the sticky overrun flag.
REQ-018 Simultaneous overrun event and clr_overrun=1: set SHALL win (overrun=1).
REQ-019 Edge in the same cycle the FSM leaves STOP to IDLE (pend_valid=0) SHALL be accepted as a new frame starting next cycle; no byte is lost.
REQ-020 Edge in the same cycle STOP hands off the pending byte SHALL be written into the freed pending slot, with no overrun.
REQ-021 The baud counter SHALL be 16 bits, count 0..CLKS_PER_BIT-1, and reset to 0 on every bit boundary; no wrap-dependent behaviour.
REQ-022 tx_serial SHALL be driven from a register, with no combinational glitch path.

Reset
REQ-023 While reset=0, the block SHALL hold:
- state IDLE, tx_serial=1, tx_busy=0, tx_done=0, tx_status=8'h00;
- pend_valid=0, overrun=0, counters 0;
- start_q=1.
REQ-024 With start_q=1 at reset, tx_start held high through reset release SHALL NOT start a frame; a fresh 0->1 transition is required.
REQ-025 Reset asserted mid-frame SHALL immediately abort: tx_serial=1 asynchronously, the pending byte is discarded, and no tx_done pulse occurs.

Verification (CLKS_PER_BIT=4)
REQ-026 Single byte: tx_data=8'hA5, tx_start 0->1 -> tx_serial = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; tx_done pulses once 40 cycles after the first 0; tx_busy=0 afterwards.
REQ-027 Back-to-back: send 8'h01, then 8'hFF pulsed during bit 3 -> tx_status=8'h03 until handoff; two contiguous 40-cycle frames with no high gap beyond the stop bit; two tx_done pulses.
REQ-028 Overrun: three edges within one frame (8'h11, 8'h22, 8'h33) -> frames 8'h11 and 8'h22 sent, 8'h33 dropped; tx_status bit2=1; clr_overrun=1 for one cycle -> bit2=0.
REQ-029 Set-vs-clear: overrun edge with clr_overrun=1 in the same cycle -> overrun=1.
REQ-030 Reset mid-frame: reset=0 during data bit 4 with a pending byte -> tx_serial=1 and tx_status=8'h00 within the reset cycle; no tx_done; no frame after release.
REQ-031 Held start: tx_start=1 across reset release -> no frame; then tx_start 0->1 -> one frame.
